memory_loader: RTL
==================

Name: memory_loader

Overview:
- Upstream write-side feeder for tri_port_memory: accepts a stream of bytes over a valid/ready handshake and assembles them little-endian into 32-bit words.
- Issues one word-mode write per word to consecutive byte addresses from a programmable base.
- Flushes a trailing partial word with half/byte-mode writes.
- Used for boot-time program/data image loading; its write outputs connect directly to the memory's write_data_in, write_address_in, write_in and memMode_in.

Parameters:
- ADDRESS_WIDTH, 8, byte-address width; must match the memory.

Ports:
- clock_in  input  1  single clock; also the memory write clock.
- reset_in  input  1  synchronous, active-high reset.
- start_in  input  1  begins a load session; sampled only in IDLE.
- base_address_in  input  ADDRESS_WIDTH  start byte address; bits [1:0] forced to 00.
- byte_data_in  input  8  stream byte.
- byte_valid_in  input  1  byte_data_in is valid.
- byte_last_in  input  1  qualifies the final byte of the session.
- byte_ready_out  output  1  loader accepts a byte this cycle.
- write_data_out  output  32  memory write data.
- write_address_out  output  ADDRESS_WIDTH  memory byte address.
- write_out  output  1  memory write strobe.
- memMode_out  output  2  00 word, 10 half (uses [15:0]), 11 byte (uses [7:0]).
- busy_out  output  1  session in progress.
- done_out  output  1  one-cycle completion pulse.
- overflow_out  output  1  sticky: address wrapped during the session.
- bytes_loaded_out  output  ADDRESS_WIDTH+1  bytes accepted in the current or last session.

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0; byte lane index 0; assembly register 0.
- All outputs are registered (Moore).
- The memory captures a write on the rising edge at the end of the cycle in which write_out=1.
- IDLE:
  - byte_ready_out=0, busy_out=0.
  - start_in=1 → addr={base[AW-1:2],2'b00}, bytes_loaded=0, overflow=0, go to COLLECT.
- COLLECT:
  - byte_ready_out=1, busy_out=1.
  - A transfer occurs when valid&ready at a rising edge: the byte goes into lane idx (idx0→[7:0] … idx3→[31:24]), idx++, bytes_loaded++.
  - idx==3 on transfer → WRITE_WORD; idx wraps to 0.
  - last on a transfer with idx<3:
    - idx==0 → FLUSH_BYTE.
    - idx==1 or 2 → FLUSH_HALF.
  - last together with the 4th byte → WRITE_WORD, then DONE.
  - Bytes are never lost: ready is low in every non-COLLECT state.
- WRITE_WORD (1 cycle):
  - write_out=1, memMode_out=00, data=assembled word, address=addr.
  - Then addr+=4; next state DONE if last was latched, else COLLECT.
  - Cost: one bubble per word, so at most 4 bytes per 5 cycles.
- FLUSH_HALF (1 cycle):
  - write_out=1, memMode_out=10, data={16'h0,lanes1:0}.
  - Then addr+=2.
  - If 3 bytes were pending: data shifts so lane2 lands in [7:0], next FLUSH_BYTE; else DONE.
- FLUSH_BYTE (1 cycle):
  - write_out=1, memMode_out=11, data={24'h0,byte}.
  - Then addr+=1 → DONE.
- DONE (1 cycle):
  - done_out=1, busy_out=0, write_out=0 → IDLE.
  - bytes_loaded_out holds its value until the next start_in.
- Address arithmetic is modulo 2^ADDRESS_WIDTH. Any increment carrying out of the MSB sets overflow_out (sticky until next start); loading continues at the wrapped address.
- write_out=0 in every state except WRITE_WORD, FLUSH_HALF and FLUSH_BYTE; write_data_out/memMode_out hold their last values when write_out=0.
- start_in while busy: ignored.
- byte_valid_in outside COLLECT: ignored.
- byte_last_in without byte_valid_in: ignored.
- reset_in mid-session: immediate return to IDLE on that edge; any write not yet strobed is discarded; outputs 0 next cycle.

Test Plan:
- Reset then idle: reset_in=1 for 2 cycles → all outputs 0, byte_ready_out=0; start_in held low → no writes.
- Two full words: base=8'h13, start, bytes 01,02,03,04,05,06,07,08 (last on 08) → writes {10,04030201,00} then {14,08070605,00}; done one cycle after the second write; bytes_loaded=8; memory readback at 0x10 = 0x04030201.
- Partial tails from base=0x20 (separate sessions):
  - 1 byte AA → single write {20,000000AA,11}.
  - 2 bytes AA,BB → single write {20,0000BBAA,10}.
  - 3 bytes AA,BB,CC → {20,0000BBAA,10} then {22,000000CC,11}.
- Throttled stream: byte_valid toggled every other cycle, 4 bytes → exactly one write, no dropped/duplicated bytes; ready=0 during the WRITE_WORD cycle.
- Wrap: base=8'hFC, 8 bytes → writes at FC then 00; overflow_out=1 after the first write, cleared on next start.
- Reset mid-session: after 2 of 4 bytes, reset_in=1 → no write issued, IDLE; a fresh session then behaves as in the two-full-words scenario.

Source files
------------

// File: rtl/memory_loader.sv
// memory_loader
//   Boot-time image feeder for tri_port_memory. Bytes arrive on a
//   valid/ready stream and are packed little-endian into 32-bit words.
//   Each complete word is written with a single word-mode write; a
//   trailing 1..3 byte remainder is written with half and/or byte-mode
//   writes. Addresses advance from a word-aligned base and wrap modulo
//   2^ADDRESS_WIDTH, with a sticky flag recording the wrap.
//
// Ports
//   clock_in           clock (also the memory write clock)
//   reset_in           synchronous active-high reset
//   start_in           begin a session (looked at only while idle)
//   base_address_in    first byte address (low two bits ignored)
//   byte_data_in       stream byte
//   byte_valid_in      stream byte valid
//   byte_last_in       final byte of the session (with valid)
//   byte_ready_out     loader accepts a byte this cycle
//   write_data_out     memory write data
//   write_address_out  memory byte address
//   write_out          memory write strobe
//   memMode_out        00 word, 10 half [15:0], 11 byte [7:0]
//   busy_out           session in progress
//   done_out           one-cycle completion pulse
//   overflow_out       sticky: address wrapped during the session
//   bytes_loaded_out   bytes accepted in the current/last session
module memory_loader #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     start_in,
  input  logic [ADDRESS_WIDTH-1:0] base_address_in,
  input  logic [7:0]               byte_data_in,
  input  logic                     byte_valid_in,
  input  logic                     byte_last_in,
  output logic                     byte_ready_out,
  output logic [31:0]              write_data_out,
  output logic [ADDRESS_WIDTH-1:0] write_address_out,
  output logic                     write_out,
  output logic [1:0]               memMode_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     overflow_out,
  output logic [ADDRESS_WIDTH:0]   bytes_loaded_out
);
  localparam int AW = ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE_WORD, S_FLUSH_HALF, S_FLUSH_BYTE, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_idx;
  logic [31:0]     r_asm, w_asm;
  logic [AW-1:0]   r_addr;
  logic            r_last;     // last arrived with the 4th byte of a word
  logic            r_pend3;    // tail of three bytes: half then byte write
  logic [AW:0]     r_cnt;
  logic            r_ovf;
  logic            r_ready, r_busy, r_done, r_write;
  logic [31:0]     r_wdata;
  logic [AW-1:0]   r_waddr;
  logic [1:0]      r_wmode;

  logic            w_xfer;
  logic [2:0]      w_inc;
  logic [AW:0]     w_sum;
  logic            w_wr_next;

  // ready is a registered copy of (state == COLLECT), so a transfer is
  // simply a valid byte seen while collecting.
  assign w_xfer = (r_state == S_COLLECT) && byte_valid_in;

  always_comb begin
    w_asm = r_asm;
    if (w_xfer) w_asm[{r_idx, 3'b000} +: 8] = byte_data_in;
  end

  // Address advance is applied on the edge that ends each write cycle.
  always_comb begin
    w_inc = 3'd0;
    case (r_state)
      S_WRITE_WORD: w_inc = 3'd4;
      S_FLUSH_HALF: w_inc = 3'd2;
      S_FLUSH_BYTE: w_inc = 3'd1;
      default:      w_inc = 3'd0;
    endcase
  end

  assign w_sum = {1'b0, r_addr} + (AW+1)'(w_inc);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start_in) w_next = S_COLLECT;
      S_COLLECT: begin
        if (w_xfer) begin
          if (r_idx == 2'd3)      w_next = S_WRITE_WORD;
          else if (byte_last_in)  w_next = (r_idx == 2'd0) ? S_FLUSH_BYTE : S_FLUSH_HALF;
        end
      end
      S_WRITE_WORD: w_next = r_last ? S_DONE : S_COLLECT;
      S_FLUSH_HALF: w_next = r_pend3 ? S_FLUSH_BYTE : S_DONE;
      S_FLUSH_BYTE: w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  assign w_wr_next = (w_next == S_WRITE_WORD) || (w_next == S_FLUSH_HALF) ||
                     (w_next == S_FLUSH_BYTE);

  always_ff @(posedge clock_in) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_idx   <= '0;
      r_asm   <= '0;
      r_addr  <= '0;
      r_last  <= 1'b0;
      r_pend3 <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_waddr <= '0;
      r_wmode <= '0;
    end else begin
      // Moore outputs: registered from the state being entered.
      r_ready <= (w_next == S_COLLECT);
      r_busy  <= (w_next == S_COLLECT) || w_wr_next;
      r_done  <= (w_next == S_DONE);
      r_write <= w_wr_next;

      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_addr  <= base_address_in & ~AW'(3);
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_pend3 <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (w_xfer) begin
            r_asm <= w_asm;
            r_idx <= r_idx + 2'd1;
            r_cnt <= r_cnt + (AW+1)'(1);
            if (r_idx == 2'd3) begin
              r_last  <= byte_last_in;
              r_wdata <= w_asm;
              r_waddr <= r_addr;
              r_wmode <= 2'b00;
            end else if (byte_last_in) begin
              r_waddr <= r_addr;
              if (r_idx == 2'd0) begin
                r_wdata <= {24'h0, byte_data_in};
                r_wmode <= 2'b11;
              end else begin
                r_wdata <= {16'h0, w_asm[15:0]};
                r_wmode <= 2'b10;
                r_pend3 <= (r_idx == 2'd2);
              end
            end
          end
        end
        S_WRITE_WORD, S_FLUSH_BYTE: begin
          r_addr <= w_sum[AW-1:0];
          if (w_sum[AW]) r_ovf <= 1'b1;
        end
        S_FLUSH_HALF: begin
          r_addr <= w_sum[AW-1:0];
          if (w_sum[AW]) r_ovf <= 1'b1;
          // Third tail byte (lane 2) goes out next as a byte write.
          if (r_pend3) begin
            r_wdata <= {24'h0, r_asm[23:16]};
            r_wmode <= 2'b11;
            r_waddr <= w_sum[AW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign byte_ready_out    = r_ready;
  assign write_data_out    = r_wdata;
  assign write_address_out = r_waddr;
  assign write_out         = r_write;
  assign memMode_out       = r_wmode;
  assign busy_out          = r_busy;
  assign done_out          = r_done;
  assign overflow_out      = r_ovf;
  assign bytes_loaded_out  = r_cnt;

endmodule
